// File: rtl/eim_bus_router.sv
// Routes single-beat EIM bus transactions to up to eight register-mapped slave
// ports, with backpressure, read-data return, timeout and error accounting.
module eim_bus_router #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                    bus_clk,
  input  logic                    reset,
  input  logic                    bus_sel,
  input  logic                    bus_wr,
  input  logic [18:0]             bus_addr,
  input  logic [15:0]             bus_data_wr,
  output logic [15:0]             bus_data_rd,
  output logic                    bus_rdy,
  output logic [NUM_PORTS-1:0]    p_sel,
  output logic                    p_wr,
  output logic [15:0]             p_addr,
  output logic [15:0]             p_wdata,
  input  logic [16*NUM_PORTS-1:0] p_rdata,
  input  logic [NUM_PORTS-1:0]    p_ack,
  input  logic                    err_clr,
  output logic                    err_flag,
  output logic [7:0]              err_count
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DERR, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  port_q, port_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rd_q, rd_d;
  logic        eflag_q, eflag_d;
  logic [7:0]  ecnt_q, ecnt_d;

  logic        ack_hit;
  logic [15:0] rdata_sel;
  logic        accept;
  logic        mapped;
  logic        err_ev;

  // Per-port mux written as a loop so the 3-bit port index never exceeds
  // the width of a narrower p_ack / p_rdata when NUM_PORTS < 8.
  always_comb begin
    ack_hit   = 1'b0;
    rdata_sel = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (port_q == 3'(k)) begin
        ack_hit   = p_ack[k];
        rdata_sel = p_rdata[16*k +: 16];
      end
    end
  end

  assign bus_rdy = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept  = bus_sel && bus_rdy;
  assign mapped  = {1'b0, bus_addr[18:16]} < 4'(NUM_PORTS);

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    tmo_d   = tmo_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_ev  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          wr_d    = bus_wr;
          addr_d  = bus_addr[15:0];
          wdata_d = bus_data_wr;
          port_d  = bus_addr[18:16];
          tmo_d   = '0;
          state_d = mapped ? S_REQ : S_DERR;
        end
      end
      S_REQ: begin
        if (ack_hit) begin
          if (!wr_q) rd_d = rdata_sel;
          state_d = S_DONE;
        end else if (tmo_q == 8'(TIMEOUT)) begin
          if (!wr_q) rd_d = 16'hDEAD;
          err_ev  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_DERR: begin
        if (!wr_q) rd_d = 16'hBAD0;
        err_ev  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A clear coinciding with an error event leaves exactly that one event counted.
  always_comb begin
    eflag_d = eflag_q;
    ecnt_d  = ecnt_q;
    if (err_clr) begin
      eflag_d = err_ev;
      ecnt_d  = {7'b0, err_ev};
    end else if (err_ev) begin
      eflag_d = 1'b1;
      if (ecnt_q != '1) ecnt_d = ecnt_q + 8'd1;
    end
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      tmo_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      eflag_q <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      tmo_q   <= tmo_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      eflag_q <= eflag_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    p_sel = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      p_sel[k] = (state_q == S_REQ) && (port_q == 3'(k));
    end
  end

  assign p_wr        = wr_q;
  assign p_addr      = addr_q;
  assign p_wdata     = wdata_q;
  assign bus_data_rd = rd_q;
  assign err_flag    = eflag_q;
  assign err_count   = ecnt_q;

endmodule

// File: tb/tb_eim_bus_router.sv
// Directed bench for eim_bus_router: transaction-level reference model checked
// every cycle, plus literal expectations taken from the worked scenarios.
module tb_eim_bus_router;

  localparam int NP  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          bus_sel = 1'b0;
  logic          bus_wr = 1'b0;
  logic [18:0]   bus_addr = '0;
  logic [15:0]   bus_data_wr = '0;
  logic [15:0]   bus_data_rd;
  logic          bus_rdy;
  logic [NP-1:0] p_sel;
  logic          p_wr;
  logic [15:0]   p_addr;
  logic [15:0]   p_wdata;
  logic [16*NP-1:0] p_rdata = {16'hC3C3, 16'h7777, 16'h1234, 16'h0F0F};
  logic [NP-1:0] p_ack = '0;
  logic          err_clr = 1'b0;
  logic          err_flag;
  logic [7:0]    err_count;

  int tests = 0;
  int fails = 0;

  eim_bus_router #(.NUM_PORTS(NP), .TIMEOUT(TMO)) dut (
    .bus_clk(clk), .reset(reset), .bus_sel(bus_sel), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_data_wr(bus_data_wr), .bus_data_rd(bus_data_rd),
    .bus_rdy(bus_rdy), .p_sel(p_sel), .p_wr(p_wr), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_ack(p_ack), .err_clr(err_clr),
    .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: free (m_rdy) or holding one outstanding transaction
  // whose target is m_port (-1 = unmapped) and which has waited m_wait cycles.
  logic        m_rdy = 1'b1;
  logic [3:0]  m_psel = '0;
  logic        m_pwr = 1'b0;
  logic [15:0] m_paddr = '0, m_pwdata = '0, m_rd = '0;
  logic        m_flag = 1'b0;
  logic [7:0]  m_cnt = '0;
  int          m_port = 0;
  int          m_wait = 0;
  logic        m_ev;

  always_comb begin
    m_ev = 1'b0;
    if (!m_rdy) begin
      if (m_port < 0) m_ev = 1'b1;
      else if (!p_ack[m_port[1:0]] && m_wait == TMO) m_ev = 1'b1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rdy <= 1'b1; m_psel <= '0; m_pwr <= 1'b0; m_paddr <= '0;
      m_pwdata <= '0; m_rd <= '0; m_flag <= 1'b0; m_cnt <= '0;
      m_port <= 0; m_wait <= 0;
    end else begin
      if (err_clr) begin
        m_flag <= m_ev;
        m_cnt  <= {7'b0, m_ev};
      end else if (m_ev) begin
        m_flag <= 1'b1;
        if (m_cnt != 8'd255) m_cnt <= m_cnt + 8'd1;
      end
      if (m_rdy) begin
        if (bus_sel) begin
          m_pwr <= bus_wr; m_paddr <= bus_addr[15:0]; m_pwdata <= bus_data_wr;
          m_rdy <= 1'b0;
          if (int'(bus_addr[18:16]) < NP) begin
            m_port <= int'(bus_addr[18:16]);
            m_wait <= 0;
            m_psel <= 4'b0001 << bus_addr[18:16];
          end else begin
            m_port <= -1;
          end
        end
      end else if (m_port < 0) begin
        if (!m_pwr) m_rd <= 16'hBAD0;
        m_rdy <= 1'b1;
      end else if (p_ack[m_port[1:0]]) begin
        if (!m_pwr) m_rd <= p_rdata[m_port[1:0]*16 +: 16];
        m_rdy <= 1'b1; m_psel <= '0;
      end else if (m_wait == TMO) begin
        if (!m_pwr) m_rd <= 16'hDEAD;
        m_rdy <= 1'b1; m_psel <= '0;
      end else begin
        m_wait <= m_wait + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("m_rdy",    32'(bus_rdy),     32'(m_rdy));
    check("m_psel",   32'(p_sel),       32'(m_psel));
    check("m_pwr",    32'(p_wr),        32'(m_pwr));
    check("m_paddr",  32'(p_addr),      32'(m_paddr));
    check("m_pwdata", 32'(p_wdata),     32'(m_pwdata));
    check("m_rd",     32'(bus_data_rd), 32'(m_rd));
    check("m_flag",   32'(err_flag),    32'(m_flag));
    check("m_cnt",    32'(err_count),   32'(m_cnt));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after accept.
  task automatic send(input logic wr, input logic [18:0] a, input logic [15:0] d);
    int n = 0;
    while (bus_rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_wait", 32'(bus_rdy), 32'd1);
    bus_sel = 1'b1; bus_wr = wr; bus_addr = a; bus_data_wr = d;
    @(negedge clk);
    bus_sel = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b1;
    tick();
    check("rst_rdy", 32'(bus_rdy), 32'd1);
    check("rst_psel", 32'(p_sel), 32'd0);
    check("rst_rd", 32'(bus_data_rd), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // read port 1, ack on the first REQ cycle
    send(1'b0, 19'h1_0040, 16'h0);
    check("rd1_psel", 32'(p_sel), 32'h2);
    check("rd1_paddr", 32'(p_addr), 32'h0040);
    check("rd1_rdy_lo", 32'(bus_rdy), 32'd0);
    p_ack = 4'b0010;
    tick();
    p_ack = '0;
    check("rd1_data", 32'(bus_data_rd), 32'h1234);
    check("rd1_rdy", 32'(bus_rdy), 32'd1);
    check("rd1_psel_off", 32'(p_sel), 32'd0);

    // write port 2, ack on the 4th REQ cycle, spurious ack from port 1 first
    send(1'b1, 19'h2_0003, 16'hA5A5);
    for (int i = 0; i < 4; i++) begin
      check("wr_psel", 32'(p_sel), 32'h4);
      check("wr_pwr", 32'(p_wr), 32'd1);
      check("wr_wdata", 32'(p_wdata), 32'hA5A5);
      check("wr_rdy_lo", 32'(bus_rdy), 32'd0);
      p_ack = (i == 3) ? 4'b0100 : (i == 0) ? 4'b0010 : 4'b0000;
      tick();
    end
    p_ack = '0;
    check("wr_rdy", 32'(bus_rdy), 32'd1);
    check("wr_rd_keep", 32'(bus_data_rd), 32'h1234);

    // acks while idle are ignored
    p_ack = '1;
    tick();
    p_ack = '0;
    check("idle_ack_psel", 32'(p_sel), 32'd0);
    check("idle_ack_rd", 32'(bus_data_rd), 32'h1234);
    tick();

    // timeout on port 0
    send(1'b0, 19'h0_0000, 16'h0);
    for (int i = 0; i < 16; i++) begin
      check("tmo_rdy_lo", 32'(bus_rdy), 32'd0);
      tick();
    end
    check("tmo_rdy", 32'(bus_rdy), 32'd1);
    check("tmo_data", 32'(bus_data_rd), 32'hDEAD);
    check("tmo_flag", 32'(err_flag), 32'd1);
    check("tmo_cnt", 32'(err_count), 32'd1);

    // unmapped reads until the counter saturates
    for (int i = 0; i < 300; i++) begin
      send(1'b0, 19'h7_0000, 16'h0);
      check("unm_psel", 32'(p_sel), 32'd0);
    end
    tick();
    check("sat_cnt", 32'(err_count), 32'd255);
    check("sat_data", 32'(bus_data_rd), 32'hBAD0);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_cnt", 32'(err_count), 32'd0);
    check("clr_flag", 32'(err_flag), 32'd0);

    // clear colliding with the DERR completion
    send(1'b0, 19'h7_0000, 16'h0);
    tick();
    send(1'b0, 19'h5_0000, 16'h0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("coll_cnt", 32'(err_count), 32'd1);
    check("coll_flag", 32'(err_flag), 32'd1);

    // unmapped write: error counted, read data untouched
    send(1'b1, 19'h6_0000, 16'h1111);
    tick();
    check("uw_cnt", 32'(err_count), 32'd2);
    check("uw_rd", 32'(bus_data_rd), 32'hBAD0);

    // reset in the middle of a request
    send(1'b0, 19'h3_0010, 16'h9999);
    check("pre_rst_psel", 32'(p_sel), 32'h8);
    #2 reset = 1'b1;
    #1;
    check("arst_rdy", 32'(bus_rdy), 32'd1);
    check("arst_psel", 32'(p_sel), 32'd0);
    check("arst_addr", 32'(p_addr), 32'd0);
    check("arst_wdata", 32'(p_wdata), 32'd0);
    check("arst_rd", 32'(bus_data_rd), 32'd0);
    check("arst_cnt", 32'(err_count), 32'd0);
    check("arst_flag", 32'(err_flag), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    send(1'b0, 19'h3_0010, 16'h0);
    tick();
    p_ack = 4'b1000;
    tick();
    p_ack = '0;
    check("post_rst_data", 32'(bus_data_rd), 32'hC3C3);
    check("post_rst_rdy", 32'(bus_rdy), 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
